regfile16_2r1w: RTL and testbench
=================================

REGFILE16_2R1W -- requirements
Module: regfile16_2r1w

Interface
REQ-001 Parameter DATA_SIZE, default 16, register and data-port width in bits.
REQ-002 Parameter REG_NUM, default 8, number of architectural registers; ADDR_W = log2(REG_NUM), default 3.
REQ-003 CLK  input  1  single clock for the block; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 WE  input  1  write-back enable.
REQ-006 W_ADDR  input  ADDR_W  write-back destination register.
REQ-007 W_DATA  input  DATA_SIZE  write-back data.
REQ-008 ISSUE  input  1  an instruction with a destination register is issued this cycle.
REQ-009 ISSUE_ADDR  input  ADDR_W  destination register of the issued instruction.
REQ-010 RA_ADDR, RB_ADDR  input  ADDR_W each  read-port A and read-port B addresses.
REQ-011 RA_DATA, RB_DATA  output  DATA_SIZE each  read data; these feed the operand-select 4-to-1 multiplexers.
REQ-012 RA_BUSY, RB_BUSY  output  1 each  addressed register awaits an outstanding write-back.

Function
REQ-013 Register array R[0..REG_NUM-1]: on a rising CLK edge with RST_N high, WE=1 and W_ADDR!=0, the block SHALL load R[W_ADDR] with W_DATA.
REQ-014 R0 SHALL read as 0 at all times; writes to R0 SHALL be ignored and SHALL NOT alter any state.
REQ-015 Reads SHALL be combinational, with zero-cycle latency: RA_DATA = R[RA_ADDR], RB_DATA = R[RB_ADDR].
REQ-016 Write-first bypass: if WE=1, W_ADDR!=0 and W_ADDR equals a read address, that port SHALL output W_DATA in the same cycle.
REQ-017 Scoreboard BUSY[0..REG_NUM-1]: on a rising edge, ISSUE=1 with ISSUE_ADDR!=0 SHALL set BUSY[ISSUE_ADDR].
REQ-018 On a rising edge, WE=1 with W_ADDR!=0 SHALL clear BUSY[W_ADDR] unless the same edge also sets it.
REQ-019 Simultaneous ISSUE and WE to the same address SHALL leave BUSY set, because a new producer supersedes the retiring one.
REQ-020 BUSY[0] SHALL remain 0 permanently.
REQ-021 RA_BUSY SHALL equal BUSY[RA_ADDR] AND NOT (WE=1 AND W_ADDR=RA_ADDR), because bypassed data is valid; RB_BUSY SHALL follow the same rule for port B.
REQ-022 RA_ADDR equal to RB_ADDR SHALL return identical data and busy on both ports.
REQ-023 An ISSUE to a register that is already busy SHALL leave it busy; no counting takes place.
REQ-024 A write to a non-busy register SHALL be legal, SHALL update the data, and SHALL leave BUSY at 0.

Reset
REQ-025 While RST_N=0, all of R[] and BUSY[] SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 While RST_N=0, writes, issues and bypass SHALL be suppressed; RA_DATA, RB_DATA, RA_BUSY and RB_BUSY SHALL all be 0.
REQ-027 Reset asserted mid-operation SHALL discard pending busy state; the first edge after RST_N deasserts SHALL behave normally.

Structure
REQ-028 A shared package SHALL hold DATA_SIZE, REG_NUM and ADDR_W constants for reuse by the operand multiplexers and the decode stage.
REQ-029 A sub-module regfile_rd_port SHALL be instantiated twice, once per read port; it SHALL contain the array select, the bypass compare, R0 forcing and the busy qualify.
REQ-030 Storage and scoreboard SHALL be flip-flop based; no memory macros.

Verification
REQ-031 Reset, then read all addresses on both ports -> RA_DATA=RB_DATA=0 and RA_BUSY=RB_BUSY=0 for every address.
REQ-032 WE=1, W_ADDR=3, W_DATA=16'hA5A5 with RA_ADDR=3 in the same cycle -> RA_DATA=16'hA5A5 in that cycle; it still reads 16'hA5A5 the next cycle with WE=0.
REQ-033 WE=1, W_ADDR=0, W_DATA=16'hFFFF, RB_ADDR=0 -> RB_DATA=0 in that cycle and the next.
REQ-034 ISSUE to R5, then RA_ADDR=5 -> RA_BUSY=1; WE to R5 with 16'h1234 -> RA_BUSY=0 and RA_DATA=16'h1234 in the same cycle, and BUSY[5]=0 afterwards.
REQ-035 ISSUE and WE both targeting R2 on one edge -> RA_BUSY (RA_ADDR=2) is 1 on the following cycle.
REQ-036 Write R7=16'h00FF and ISSUE R6, then pulse RST_N low between clock edges -> outputs go to 0 immediately, and R7 reads 0 and R6 not busy after release.

Source files
------------

// File: rtl/regfile16_2r1w_pkg.sv
// Shared sizing constants for the register file, operand muxes and decode stage.
package regfile16_2r1w_pkg;

    localparam int DATA_SIZE = 16;
    localparam int REG_NUM   = 8;
    localparam int ADDR_W    = $clog2(REG_NUM);

endpackage : regfile16_2r1w_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port: array select, write-first bypass, R0 forcing
// and busy qualification (bypassed data is already valid, so not busy).
module regfile_rd_port
    import regfile16_2r1w_pkg::*;
#(
    parameter int P_DATA_SIZE = DATA_SIZE,
    parameter int P_REG_NUM   = REG_NUM,
    parameter int P_ADDR_W    = $clog2(P_REG_NUM)
) (
    input  logic [P_REG_NUM-1:0][P_DATA_SIZE-1:0] i_regs,
    input  logic [P_REG_NUM-1:0]                  i_busy,
    input  logic [P_ADDR_W-1:0]                   i_addr,
    input  logic                                  i_wr_en,
    input  logic [P_ADDR_W-1:0]                   i_wr_addr,
    input  logic [P_DATA_SIZE-1:0]                i_wr_data,
    output logic [P_DATA_SIZE-1:0]                o_data,
    output logic                                  o_busy
);

    logic w_hit;

    // i_wr_en already excludes R0 and reset, so a hit is always a real write.
    assign w_hit = i_wr_en && (i_wr_addr == i_addr);

    // Select read data, with R0 hard-wired to zero ahead of the bypass.
    always_comb begin
        o_data = i_regs[i_addr];
        if (i_addr == '0) begin
            o_data = '0;
        end else if (w_hit) begin
            o_data = i_wr_data;
        end
    end

    // Busy is masked when the retiring write is being forwarded this cycle.
    always_comb begin
        o_busy = i_busy[i_addr] & ~w_hit;
    end

endmodule : regfile_rd_port

// File: rtl/regfile16_2r1w.sv
// Two-read / one-write flip-flop register file with a per-register busy
// scoreboard. R0 reads zero; reads are combinational with write-first bypass.
module regfile16_2r1w
    import regfile16_2r1w_pkg::*;
#(
    parameter int DATA_SIZE = regfile16_2r1w_pkg::DATA_SIZE,
    parameter int REG_NUM   = regfile16_2r1w_pkg::REG_NUM,
    parameter int ADDR_W    = $clog2(REG_NUM)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_w_addr,
    input  logic [DATA_SIZE-1:0] i_w_data,
    input  logic                 i_issue,
    input  logic [ADDR_W-1:0]    i_issue_addr,
    input  logic [ADDR_W-1:0]    i_ra_addr,
    input  logic [ADDR_W-1:0]    i_rb_addr,
    output logic [DATA_SIZE-1:0] o_ra_data,
    output logic [DATA_SIZE-1:0] o_rb_data,
    output logic                 o_ra_busy,
    output logic                 o_rb_busy
);

    localparam logic [REG_NUM-1:0] ONE_HOT_R0 = REG_NUM'(1);

    logic [REG_NUM-1:0][DATA_SIZE-1:0] r_regs;
    logic [REG_NUM-1:0]                r_busy;
    logic                              w_wr_en;
    logic                              w_issue_en;
    logic [REG_NUM-1:0]                w_wr_dec;
    logic [REG_NUM-1:0]                w_issue_dec;

    // Qualify write and issue: R0 targets are dropped, and nothing (including
    // the combinational bypass) is allowed through while reset is held.
    assign w_wr_en    = i_rst_n && i_we    && (i_w_addr != '0);
    assign w_issue_en = i_rst_n && i_issue && (i_issue_addr != '0);

    // One-hot decodes with bit 0 masked so R0 state can never change.
    always_comb begin
        w_wr_dec    = '0;
        w_issue_dec = '0;
        if (w_wr_en) begin
            w_wr_dec = (ONE_HOT_R0 << i_w_addr) & ~ONE_HOT_R0;
        end
        if (w_issue_en) begin
            w_issue_dec = (ONE_HOT_R0 << i_issue_addr) & ~ONE_HOT_R0;
        end
    end

    // Register storage; R0 is never loaded after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_regs <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (w_wr_dec[i]) begin
                    r_regs[i] <= i_w_data;
                end
            end
        end
    end

    // Scoreboard: retire clears, issue sets; a same-edge issue wins because the
    // new producer supersedes the retiring one. Re-issue simply stays set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_wr_dec) | w_issue_dec) & ~ONE_HOT_R0;
        end
    end

    regfile_rd_port #(
        .P_DATA_SIZE (DATA_SIZE),
        .P_REG_NUM   (REG_NUM),
        .P_ADDR_W    (ADDR_W)
    ) u_rd_port_a (
        .i_regs    (r_regs),
        .i_busy    (r_busy),
        .i_addr    (i_ra_addr),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_w_addr),
        .i_wr_data (i_w_data),
        .o_data    (o_ra_data),
        .o_busy    (o_ra_busy)
    );

    regfile_rd_port #(
        .P_DATA_SIZE (DATA_SIZE),
        .P_REG_NUM   (REG_NUM),
        .P_ADDR_W    (ADDR_W)
    ) u_rd_port_b (
        .i_regs    (r_regs),
        .i_busy    (r_busy),
        .i_addr    (i_rb_addr),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_w_addr),
        .i_wr_data (i_w_data),
        .o_data    (o_rb_data),
        .o_busy    (o_rb_busy)
    );

endmodule : regfile16_2r1w

// File: tb/tb_regfile16_2r1w.sv
// Directed bench for regfile16_2r1w with hand-computed expectations.
module tb_regfile16_2r1w;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic        issue;
    logic [2:0]  issue_addr;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        ra_busy;
    logic        rb_busy;

    int n_checks = 0;
    int n_errors = 0;

    regfile16_2r1w dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_we         (we),
        .i_w_addr     (w_addr),
        .i_w_data     (w_data),
        .i_issue      (issue),
        .i_issue_addr (issue_addr),
        .i_ra_addr    (ra_addr),
        .i_rb_addr    (rb_addr),
        .o_ra_data    (ra_data),
        .o_rb_data    (rb_data),
        .o_ra_busy    (ra_busy),
        .o_rb_busy    (rb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; w_addr = '0; w_data = '0;
        issue = 1'b0; issue_addr = '0; ra_addr = '0; rb_addr = '0;
        #12;
        chk("rst_ra_data", ra_data, 16'h0);
        chk("rst_ra_busy", {15'b0, ra_busy}, 16'h0);
        #5;
        rst_n = 1'b1;
        tick();

        // All addresses read zero and not busy after reset
        for (int a = 0; a < 8; a++) begin
            ra_addr = 3'(a);
            rb_addr = 3'(7 - a);
            #1;
            chk($sformatf("init_ra_data[%0d]", a), ra_data, 16'h0);
            chk($sformatf("init_rb_data[%0d]", 7 - a), rb_data, 16'h0);
            chk($sformatf("init_ra_busy[%0d]", a), {15'b0, ra_busy}, 16'h0);
            chk($sformatf("init_rb_busy[%0d]", 7 - a), {15'b0, rb_busy}, 16'h0);
        end

        // Write R3 with same-cycle bypass, then read from storage
        tick();
        we = 1'b1; w_addr = 3'd3; w_data = 16'hA5A5; ra_addr = 3'd3; rb_addr = 3'd4;
        #1;
        chk("byp_r3_ra", ra_data, 16'hA5A5);
        chk("byp_r3_rb_other", rb_data, 16'h0);
        tick();
        we = 1'b0; w_data = 16'h0;
        #1;
        chk("stored_r3_ra", ra_data, 16'hA5A5);

        // Write to R0 is ignored, including bypass
        we = 1'b1; w_addr = 3'd0; w_data = 16'hFFFF; rb_addr = 3'd0;
        #1;
        chk("r0_byp_rb", rb_data, 16'h0);
        chk("r0_byp_rb_busy", {15'b0, rb_busy}, 16'h0);
        tick();
        we = 1'b0;
        #1;
        chk("r0_after_rb", rb_data, 16'h0);
        chk("r3_kept", ra_data, 16'hA5A5);

        // Issue R5, then retire it with bypass clearing busy in the same cycle
        issue = 1'b1; issue_addr = 3'd5;
        tick();
        issue = 1'b0; ra_addr = 3'd5; rb_addr = 3'd5;
        #1;
        chk("r5_busy_ra", {15'b0, ra_busy}, 16'h1);
        chk("r5_busy_rb", {15'b0, rb_busy}, 16'h1);
        we = 1'b1; w_addr = 3'd5; w_data = 16'h1234;
        #1;
        chk("r5_wb_ra_busy", {15'b0, ra_busy}, 16'h0);
        chk("r5_wb_ra_data", ra_data, 16'h1234);
        chk("r5_wb_rb_data", rb_data, 16'h1234);
        tick();
        we = 1'b0;
        #1;
        chk("r5_after_busy", {15'b0, ra_busy}, 16'h0);
        chk("r5_after_data", ra_data, 16'h1234);

        // Issue and write-back to R2 on one edge: busy stays set
        issue = 1'b1; issue_addr = 3'd2; we = 1'b1; w_addr = 3'd2; w_data = 16'h5555;
        ra_addr = 3'd2; rb_addr = 3'd2;
        tick();
        issue = 1'b0; we = 1'b0;
        #1;
        chk("r2_coll_busy", {15'b0, ra_busy}, 16'h1);
        chk("r2_coll_data", ra_data, 16'h5555);
        // Re-issue of a busy register: still busy, then one write clears it
        issue = 1'b1; issue_addr = 3'd2;
        tick();
        issue = 1'b0;
        #1;
        chk("r2_reissue_busy", {15'b0, rb_busy}, 16'h1);
        we = 1'b1; w_addr = 3'd2; w_data = 16'h0C0C;
        tick();
        we = 1'b0;
        #1;
        chk("r2_clear_busy", {15'b0, ra_busy}, 16'h0);
        chk("r2_clear_data", rb_data, 16'h0C0C);

        // Write to a non-busy register leaves busy at zero
        we = 1'b1; w_addr = 3'd4; w_data = 16'hBEEF;
        tick();
        we = 1'b0; ra_addr = 3'd4;
        #1;
        chk("r4_data", ra_data, 16'hBEEF);
        chk("r4_busy", {15'b0, ra_busy}, 16'h0);

        // Mid-operation reset pulse between edges
        we = 1'b1; w_addr = 3'd7; w_data = 16'h00FF; issue = 1'b1; issue_addr = 3'd6;
        tick();
        we = 1'b0; issue = 1'b0; ra_addr = 3'd7; rb_addr = 3'd6;
        #1;
        chk("pre_rst_r7", ra_data, 16'h00FF);
        chk("pre_rst_r6_busy", {15'b0, rb_busy}, 16'h1);
        rst_n = 1'b0;
        we = 1'b1; w_addr = 3'd7; w_data = 16'h7777;
        #1;
        chk("in_rst_ra_data", ra_data, 16'h0);
        chk("in_rst_rb_busy", {15'b0, rb_busy}, 16'h0);
        rb_addr = 3'd4;
        #1;
        chk("in_rst_rb_data", rb_data, 16'h0);
        we = 1'b0; rb_addr = 3'd6;
        rst_n = 1'b1;
        #1;
        chk("post_rst_r7", ra_data, 16'h0);
        chk("post_rst_r6_busy", {15'b0, rb_busy}, 16'h0);

        // First edge after release behaves normally
        we = 1'b1; w_addr = 3'd1; w_data = 16'h0BAD; ra_addr = 3'd1;
        tick();
        we = 1'b0;
        #1;
        chk("post_rst_write_r1", ra_data, 16'h0BAD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regfile16_2r1w
